// File: rtl/pio_pulse_arbiter.sv
// Round-robin arbiter that lets several requesters share one PIO strobe line:
// each grant writes 1 to the PIO data register, holds it for pulse_len cycles, writes 0, then acks.
module pio_pulse_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [CNT_W-1:0]   pulse_len,
  output logic [NUM_REQ-1:0] gnt,
  output logic [NUM_REQ-1:0] ack,
  output logic               busy,
  output logic [1:0]         pio_address,
  output logic               pio_chipselect,
  output logic               pio_write_n,
  output logic [31:0]        pio_writedata
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {S_IDLE, S_WR_ON, S_HOLD, S_WR_OFF, S_ACK} state_t;

  state_t             r_state;
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   r_owner;
  logic [CNT_W-1:0]   r_len;
  logic [CNT_W-1:0]   r_cnt;
  logic [NUM_REQ-1:0] r_gnt;
  logic [NUM_REQ-1:0] r_ack;
  logic               r_busy;
  logic               r_cs;
  logic               r_wn;
  logic               r_wd;

  logic               w_found;
  logic [PTR_W-1:0]   w_idx;
  logic [PTR_W:0]     w_sum;
  logic [NUM_REQ-1:0] w_onehot;
  logic [CNT_W-1:0]   w_len;
  logic [PTR_W-1:0]   w_ptr_next;

  // First set request at or above the pointer, wrapping at NUM_REQ-1.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_sum   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_sum = {1'b0, r_ptr} + (PTR_W+1)'(i);
      if (w_sum >= (PTR_W+1)'(NUM_REQ))
        w_sum = w_sum - (PTR_W+1)'(NUM_REQ);
      if (!w_found && req[w_sum[PTR_W-1:0]]) begin
        w_found = 1'b1;
        w_idx   = w_sum[PTR_W-1:0];
      end
    end
  end

  assign w_onehot   = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_idx;
  assign w_len      = (pulse_len == '0) ? CNT_ONE : pulse_len;
  assign w_ptr_next = (r_owner == PTR_W'(NUM_REQ-1)) ? '0 : r_owner + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_gnt   <= '0;
      r_ack   <= '0;
      r_busy  <= 1'b0;
      r_cs    <= 1'b0;
      r_wn    <= 1'b1;
      r_wd    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state <= S_WR_ON;
            r_gnt   <= w_onehot;
            r_owner <= w_idx;
            r_len   <= w_len;
            r_busy  <= 1'b1;
            r_cs    <= 1'b1;
            r_wn    <= 1'b0;
            r_wd    <= 1'b1;
          end
        end
        S_WR_ON: begin
          r_cnt <= r_len - CNT_ONE;
          r_wd  <= 1'b0;
          // A one-cycle pulse skips HOLD, so the write strobe stays asserted for WR_OFF.
          if (r_len == CNT_ONE) begin
            r_state <= S_WR_OFF;
          end else begin
            r_state <= S_HOLD;
            r_cs    <= 1'b0;
            r_wn    <= 1'b1;
          end
        end
        S_HOLD: begin
          r_cnt <= r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) begin
            r_state <= S_WR_OFF;
            r_cs    <= 1'b1;
            r_wn    <= 1'b0;
          end
        end
        S_WR_OFF: begin
          r_state <= S_ACK;
          r_cs    <= 1'b0;
          r_wn    <= 1'b1;
          r_ack   <= r_gnt;
        end
        S_ACK: begin
          r_state <= S_IDLE;
          r_ack   <= '0;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
          r_ptr   <= w_ptr_next;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt            = r_gnt;
  assign ack            = r_ack;
  assign busy           = r_busy;
  assign pio_address    = '0;
  assign pio_chipselect = r_cs;
  assign pio_write_n    = r_wn;
  assign pio_writedata  = {31'b0, r_wd};

endmodule

// File: tb/tb_pio_pulse_arbiter.sv
// Bench for pio_pulse_arbiter: directed scenarios plus random traffic, compared cycle by cycle
// against a timing-based transaction model and a behavioural PIO data register.
module tb_pio_pulse_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req;
  logic [7:0]  pulse_len;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic        busy;
  logic [1:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;
  logic        pio_out;

  int vectors;
  int miscompares;
  int n;
  bit m_active;
  int m_t;
  int m_L;
  int m_owner;
  int m_ptr;

  pio_pulse_arbiter #(.NUM_REQ(4), .CNT_W(8)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req            (req),
    .pulse_len      (pulse_len),
    .gnt            (gnt),
    .ack            (ack),
    .busy           (busy),
    .pio_address    (pio_address),
    .pio_chipselect (pio_chipselect),
    .pio_write_n    (pio_write_n),
    .pio_writedata  (pio_writedata)
  );

  always #5 clk = ~clk;

  // Behavioural PIO data register sharing reset_n.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      pio_out <= 1'b0;
    else if (pio_chipselect && !pio_write_n && pio_address == 2'd0)
      pio_out <= pio_writedata[0];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, n);
    end
  endtask

  // Expected outputs derived from the offset d since the sampling cycle t of the current pulse.
  task automatic check_outputs();
    int d;
    logic [3:0] oh;
    bit wr;
    d  = n - m_t;
    oh = m_active ? (4'b0001 << m_owner) : 4'b0000;
    wr = m_active && (d == 1 || d == m_L + 1);
    check("gnt",       {28'b0, gnt}, {28'b0, oh});
    check("busy",      {31'b0, busy}, {31'b0, m_active});
    check("ack",       {28'b0, ack}, (m_active && d == m_L + 2) ? {28'b0, oh} : 32'd0);
    check("chipsel",   {31'b0, pio_chipselect}, {31'b0, wr});
    check("write_n",   {31'b0, pio_write_n}, {31'b0, !wr});
    check("writedata", pio_writedata, (m_active && d == 1) ? 32'd1 : 32'd0);
    check("address",   {30'b0, pio_address}, 32'd0);
    check("pio_out",   {31'b0, pio_out}, {31'b0, (m_active && d >= 2 && d <= m_L + 1)});
    check("onehot",    ($countones(gnt) <= 1) ? 32'd1 : 32'd0, 32'd1);
  endtask

  // Advances the model across the rising edge that ends cycle n.
  task automatic model_update();
    if (!reset_n) begin
      m_active = 1'b0;
      m_ptr    = 0;
    end else if (m_active) begin
      if (n - m_t == m_L + 2) begin
        m_active = 1'b0;
        m_ptr    = (m_owner + 1) % 4;
      end
    end else if (req != 4'b0000) begin
      for (int k = 0; k < 4; k++) begin
        int i;
        i = (m_ptr + k) % 4;
        if (req[i]) begin
          m_owner = i;
          break;
        end
      end
      m_t      = n;
      m_L      = (pulse_len == 8'd0) ? 1 : int'(pulse_len);
      m_active = 1'b1;
    end
    n++;
  endtask

  task automatic step(input logic [3:0] r, input int len, input bit rst);
    @(negedge clk);
    check_outputs();
    req       = r;
    pulse_len = len[7:0];
    reset_n   = rst;
    model_update();
  endtask

  task automatic run(input logic [3:0] r, input int len, input bit rst, input int cycles);
    for (int c = 0; c < cycles; c++) step(r, len, rst);
  endtask

  // Asserts reset mid-cycle and checks that outputs clear without waiting for a clock edge.
  task automatic reset_mid(input logic [3:0] r);
    @(negedge clk);
    check_outputs();
    req = r;
    #2 reset_n = 1'b0;
    #1;
    m_active = 1'b0;
    m_ptr    = 0;
    check_outputs();
    model_update();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    n           = 0;
    m_active    = 1'b0;
    m_t         = 0;
    m_L         = 1;
    m_owner     = 0;
    m_ptr       = 0;
    req         = '0;
    pulse_len   = '0;
    reset_n     = 1'b1;
    #1 reset_n  = 1'b0;

    run(4'b0000, 0, 1'b0, 3);
    run(4'b0000, 0, 1'b1, 2);

    run(4'b0010, 5, 1'b1, 8);
    run(4'b0000, 0, 1'b1, 2);

    run(4'b0001, 0, 1'b1, 4);
    run(4'b0000, 0, 1'b1, 2);
    run(4'b0001, 1, 1'b1, 4);
    run(4'b0000, 0, 1'b1, 2);

    run(4'b1111, 2, 1'b1, 25);
    run(4'b0000, 0, 1'b1, 3);

    run(4'b0100, 2, 1'b1, 5);
    run(4'b0000, 0, 1'b1, 1);
    run(4'b1001, 2, 1'b1, 5);
    run(4'b0001, 2, 1'b1, 5);
    run(4'b0000, 0, 1'b1, 2);

    run(4'b0010, 10, 1'b1, 3);
    run(4'b0000, 3, 1'b1, 12);
    run(4'b0000, 0, 1'b1, 2);

    run(4'b0001, 255, 1'b1, 258);
    run(4'b0000, 0, 1'b1, 2);

    run(4'b0100, 8, 1'b1, 4);
    reset_mid(4'b0010);
    run(4'b0010, 4, 1'b0, 2);
    run(4'b0010, 4, 1'b1, 7);
    run(4'b0000, 0, 1'b1, 2);

    for (int c = 0; c < 400; c++) begin
      logic [3:0] rr;
      rr = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      step(rr, int'($urandom_range(0, 6)), 1'b1);
    end
    run(4'b0000, 0, 1'b1, 12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
